// File: rtl/nrx_rom_arbiter.sv
// nrx_rom_arbiter
//   Shares one external program-ROM memory port between the Z80 fetch path
//   and the ROM download writer. Download writes have priority over CPU
//   reads. A one-entry read tag holds the last fetched byte, so a stable CPU
//   address is not refetched. The CPU is stalled through cpu_wait_n until the
//   tag holds its address.
//
// Optional feature (macro NRX_ROM_ARB_PREFETCH_EN):
//   A second tag (pf) is filled speculatively with cpu_addr+1 after each
//   completed CPU read. A later miss that matches pf is served from it with no
//   memory access, and pf is promoted to the main tag in one cycle.
//
// Parameters
//   ADDR_W    external memory address width
//   CPU_BASE  offset added to the 15-bit CPU address to form mem_addr
//   ACK_TMO   cycles to wait for mem_ack before abandoning an access (1..255)
//
// Ports
//   CLK24M, RESET          clock, synchronous active-high reset
//   cpu_addr/cpu_oe        CPU ROM address and level read strobe
//   cpu_data/cpu_wait_n    ROM byte to the CPU, stall request (low = wait)
//   dl_we/dl_addr/dl_data  download byte strobe (one cycle per byte)
//   dl_busy/dl_ovf         buffer occupied / sticky dropped-byte flag
//   mem_req/mem_we/mem_addr/mem_wdata  request held until mem_ack
//   mem_ack/mem_rdata      one-cycle completion pulse with read data
//   tmo_err                sticky: an access timed out
module nrx_rom_arbiter #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] CPU_BASE = '0,
  parameter int                ACK_TMO  = 255
) (
  input  logic              CLK24M,
  input  logic              RESET,
  input  logic [14:0]       cpu_addr,
  input  logic              cpu_oe,
  output logic [7:0]        cpu_data,
  output logic              cpu_wait_n,
  input  logic              dl_we,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_busy,
  output logic              dl_ovf,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              tmo_err
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_GAP, S_PF} state_t;

  // Counter is cleared on entry, so the last permitted cycle is ACK_TMO-1.
  localparam logic [7:0] TMO_LAST = 8'(ACK_TMO - 1);

  state_t            state_q, state_d;
  logic [7:0]        tmo_cnt;
  logic              tag_valid;
  logic [14:0]       tag_addr;
  logic [7:0]        tag_data;
  logic [14:0]       rd_addr;
  logic [ADDR_W-1:0] dl_addr_buf;
  logic [7:0]        dl_data_buf;
  logic              hit_main, miss, in_access, timeout, acc_done;
  logic              wr_retire, dl_accept, start_rd, start_wr, start_acc;
`ifdef NRX_ROM_ARB_PREFETCH_EN
  logic              pf_valid, pf_pend, pf_hit, start_pf, promote;
  logic [14:0]       pf_addr, pf_next;
  logic [7:0]        pf_data;
`endif

  // CPU-side hit detection and stall
  always_comb begin
    hit_main = tag_valid && (tag_addr == cpu_addr);
    miss     = cpu_oe && !hit_main;
`ifdef NRX_ROM_ARB_PREFETCH_EN
    pf_hit     = pf_valid && (pf_addr == cpu_addr);
    cpu_wait_n = !(cpu_oe && !(hit_main || pf_hit));
    // Serve a pf match immediately; promotion into the main tag follows.
    cpu_data   = (pf_hit && !hit_main) ? pf_data : tag_data;
    in_access  = (state_q == S_RD) || (state_q == S_WR) || (state_q == S_PF);
`else
    cpu_wait_n = !miss;
    cpu_data   = tag_data;
    in_access  = (state_q == S_RD) || (state_q == S_WR);
`endif
    timeout   = (tmo_cnt == TMO_LAST);
    acc_done  = in_access && (mem_ack || timeout);
    wr_retire = (state_q == S_WR) && acc_done;
    // A byte arriving as the buffer retires is taken, not dropped.
    dl_accept = dl_we && (!dl_busy || wr_retire);
    mem_req   = in_access;
    mem_we    = (state_q == S_WR);
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    start_rd = 1'b0;
    start_wr = 1'b0;
`ifdef NRX_ROM_ARB_PREFETCH_EN
    start_pf = 1'b0;
    promote  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (dl_busy) begin
          state_d  = S_WR;
          start_wr = 1'b1;
        end else if (miss) begin
`ifdef NRX_ROM_ARB_PREFETCH_EN
          if (pf_hit) begin
            promote = 1'b1;
          end else begin
            state_d  = S_RD;
            start_rd = 1'b1;
          end
`else
          state_d  = S_RD;
          start_rd = 1'b1;
`endif
        end
`ifdef NRX_ROM_ARB_PREFETCH_EN
        else if (pf_pend) begin
          state_d  = S_PF;
          start_pf = 1'b1;
        end
`endif
      end
      S_RD, S_WR, S_PF: if (acc_done) state_d = S_GAP;
      S_GAP:            state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
`ifdef NRX_ROM_ARB_PREFETCH_EN
    start_acc = start_rd || start_wr || start_pf;
`else
    start_acc = start_rd || start_wr;
`endif
  end

  // State, request, buffer and tag registers
  always_ff @(posedge CLK24M) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      tmo_cnt     <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rd_addr     <= '0;
      tag_valid   <= 1'b0;
      tag_addr    <= '0;
      tag_data    <= '0;
      dl_busy     <= 1'b0;
      dl_ovf      <= 1'b0;
      dl_addr_buf <= '0;
      dl_data_buf <= '0;
      tmo_err     <= 1'b0;
`ifdef NRX_ROM_ARB_PREFETCH_EN
      pf_valid    <= 1'b0;
      pf_pend     <= 1'b0;
      pf_addr     <= '0;
      pf_next     <= '0;
      pf_data     <= '0;
`endif
    end else begin
      state_q <= state_d;

      if (start_acc)      tmo_cnt <= '0;
      else if (in_access) tmo_cnt <= tmo_cnt + 8'd1;

      if (start_rd) begin
        mem_addr <= CPU_BASE + ADDR_W'({1'b0, cpu_addr});
        rd_addr  <= cpu_addr;
      end
      if (start_wr) begin
        mem_addr  <= dl_addr_buf;
        mem_wdata <= dl_data_buf;
      end

      if (in_access && !mem_ack && timeout) tmo_err <= 1'b1;

      if (dl_accept) begin
        dl_addr_buf <= dl_addr;
        dl_data_buf <= dl_data;
        dl_busy     <= 1'b1;
      end else if (wr_retire) begin
        dl_busy <= 1'b0;
      end
      if (dl_we && dl_busy && !wr_retire) dl_ovf <= 1'b1;

      // A timed-out read releases the CPU with 8'hFF.
      if ((state_q == S_RD) && acc_done) begin
        tag_addr  <= rd_addr;
        tag_data  <= mem_ack ? mem_rdata : 8'hFF;
        tag_valid <= 1'b1;
      end

`ifdef NRX_ROM_ARB_PREFETCH_EN
      if (start_pf) begin
        mem_addr <= CPU_BASE + ADDR_W'({1'b0, pf_next});
        pf_pend  <= 1'b0;
      end
      // Schedule a prefetch only when nothing else is waiting for the port.
      if ((state_q == S_RD) && mem_ack && !dl_busy &&
          !(cpu_oe && (cpu_addr != rd_addr))) begin
        pf_pend <= 1'b1;
        pf_next <= rd_addr + 15'd1;
      end
      if ((state_q == S_PF) && mem_ack) begin
        pf_addr  <= pf_next;
        pf_data  <= mem_rdata;
        pf_valid <= 1'b1;
      end
      if (promote) begin
        tag_addr  <= pf_addr;
        tag_data  <= pf_data;
        tag_valid <= 1'b1;
        pf_valid  <= 1'b0;
      end
`endif

      // ROM contents are changing: any cached byte may be stale.
      if (dl_accept) begin
        tag_valid <= 1'b0;
`ifdef NRX_ROM_ARB_PREFETCH_EN
        pf_valid  <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_nrx_rom_arbiter.sv
// tb_nrx_rom_arbiter
//   Directed per-cycle vector table for the main read/download sequences,
//   followed by hand-written timeout and reset-during-access sequences.
module tb_nrx_rom_arbiter;

  logic        CLK24M;
  logic        RESET;
  logic [14:0] cpu_addr;
  logic        cpu_oe;
  logic [7:0]  cpu_data;
  logic        cpu_wait_n;
  logic        dl_we;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_busy;
  logic        dl_ovf;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        tmo_err;

  nrx_rom_arbiter #(.ADDR_W(16), .CPU_BASE(16'h0000), .ACK_TMO(8)) dut (
    .CLK24M(CLK24M), .RESET(RESET),
    .cpu_addr(cpu_addr), .cpu_oe(cpu_oe), .cpu_data(cpu_data), .cpu_wait_n(cpu_wait_n),
    .dl_we(dl_we), .dl_addr(dl_addr), .dl_data(dl_data), .dl_busy(dl_busy), .dl_ovf(dl_ovf),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .tmo_err(tmo_err)
  );

  initial CLK24M = 1'b0;
  always #5 CLK24M = ~CLK24M;

  typedef struct packed {
    logic        oe;
    logic [14:0] ca;
    logic        dw;
    logic [15:0] da;
    logic [7:0]  dd;
    logic        ack;
    logic [7:0]  rd;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic        wn;
    logic [7:0]  data;
    logic        busy;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic oe, logic [14:0] ca, logic dw, logic [15:0] da,
                              logic [7:0] dd, logic ack, logic [7:0] rd, logic req,
                              logic we, logic [15:0] addr, logic [7:0] wd, logic wn,
                              logic [7:0] data, logic busy, logic ovf);
    vec_t v;
    v = {oe, ca, dw, da, dd, ack, rd, req, we, addr, wd, wn, data, busy, ovf};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK24M);
    #1;
  endtask

  initial begin
    int  n_hi;
    bit  ended;

    RESET = 1'b1; cpu_oe = 1'b0; cpu_addr = '0; dl_we = 1'b0; dl_addr = '0;
    dl_data = '0; mem_ack = 1'b0; mem_rdata = '0;

`ifdef NRX_ROM_ARB_PREFETCH_EN
    //             oe ca       dw da       dd     ack rd     req we addr      wd     wn data   busy ovf
    vecs.push_back(mk(1, 15'h7FFF, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 15'h7FFF, 0, 16'h0000, 8'h00, 1, 8'hC1, 1, 0, 16'h7FFF, 8'h00, 0, 8'h00, 0, 0));
    vecs.push_back(mk(1, 15'h7FFF, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'hC1, 0, 0));
    vecs.push_back(mk(1, 15'h7FFF, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'hC1, 0, 0));
    vecs.push_back(mk(1, 15'h7FFF, 0, 16'h0000, 8'h00, 1, 8'hC2, 1, 0, 16'h0000, 8'h00, 1, 8'hC1, 0, 0));
    vecs.push_back(mk(1, 15'h7FFF, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'hC1, 0, 0));
    vecs.push_back(mk(1, 15'h0000, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'hC2, 0, 0));
    vecs.push_back(mk(1, 15'h0000, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'hC2, 0, 0));
    vecs.push_back(mk(1, 15'h0000, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'hC2, 0, 0));
`else
    // First miss: req at 1, ack at 3, released at 4
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0)); // 0
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 0, 16'h0010, 8'h00, 0, 8'h00, 0, 0)); // 1
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 0, 16'h0010, 8'h00, 0, 8'h00, 0, 0)); // 2
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 1, 8'h3E, 1, 0, 16'h0010, 8'h00, 0, 8'h00, 0, 0)); // 3
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h3E, 0, 0)); // 4
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h3E, 0, 0)); // 5
    // Repeat read of the cached address: no request
    vecs.push_back(mk(0, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h3E, 0, 0)); // 6
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h3E, 0, 0)); // 7
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h3E, 0, 0)); // 8
    // Download byte invalidates the tag, WR has priority over the miss
    vecs.push_back(mk(0, 15'h0010, 1, 16'h6000, 8'h11, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h3E, 0, 0)); // 9
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h3E, 1, 0)); // 10
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 1, 16'h6000, 8'h11, 0, 8'h3E, 1, 0)); // 11
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 1, 8'h77, 1, 1, 16'h6000, 8'h11, 0, 8'h3E, 1, 0)); // 12
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h3E, 0, 0)); // 13
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h3E, 0, 0)); // 14
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 1, 8'h3F, 1, 0, 16'h0010, 8'h00, 0, 8'h3E, 0, 0)); // 15
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h3F, 0, 0)); // 16
    // Miss on 0x20 with a download byte arriving during the read
    vecs.push_back(mk(1, 15'h0020, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h3F, 0, 0)); // 17
    vecs.push_back(mk(1, 15'h0020, 1, 16'h6000, 8'hA5, 0, 8'h00, 1, 0, 16'h0020, 8'h00, 0, 8'h3F, 0, 0)); // 18
    vecs.push_back(mk(1, 15'h0020, 0, 16'h0000, 8'h00, 1, 8'h5A, 1, 0, 16'h0020, 8'h00, 0, 8'h3F, 1, 0)); // 19
    vecs.push_back(mk(1, 15'h0020, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h5A, 1, 0)); // 20
    vecs.push_back(mk(1, 15'h0020, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h5A, 1, 0)); // 21
    vecs.push_back(mk(1, 15'h0020, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 1, 16'h6000, 8'hA5, 1, 8'h5A, 1, 0)); // 22
    vecs.push_back(mk(1, 15'h0020, 0, 16'h0000, 8'h00, 1, 8'h00, 1, 1, 16'h6000, 8'hA5, 1, 8'h5A, 1, 0)); // 23
    // 0x10 must be refetched
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h5A, 0, 0)); // 24
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h5A, 0, 0)); // 25
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 1, 8'h3F, 1, 0, 16'h0010, 8'h00, 0, 8'h5A, 0, 0)); // 26
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h3F, 0, 0)); // 27
    // dl_we coinciding with WR ack is accepted; a later byte while busy is dropped
    vecs.push_back(mk(0, 15'h0010, 1, 16'h7000, 8'hB1, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h3F, 0, 0)); // 28
    vecs.push_back(mk(0, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h3F, 1, 0)); // 29
    vecs.push_back(mk(0, 15'h0010, 1, 16'h7002, 8'hB3, 1, 8'h00, 1, 1, 16'h7000, 8'hB1, 1, 8'h3F, 1, 0)); // 30
    vecs.push_back(mk(0, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h3F, 1, 0)); // 31
    vecs.push_back(mk(0, 15'h0010, 1, 16'h7003, 8'hB4, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h3F, 1, 0)); // 32
    vecs.push_back(mk(0, 15'h0010, 0, 16'h0000, 8'h00, 1, 8'h00, 1, 1, 16'h7002, 8'hB3, 1, 8'h3F, 1, 1)); // 33
    vecs.push_back(mk(0, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h3F, 0, 1)); // 34
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h3F, 0, 1)); // 35
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 1, 8'h44, 1, 0, 16'h0010, 8'h00, 0, 8'h3F, 0, 1)); // 36
    vecs.push_back(mk(1, 15'h0010, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h44, 0, 1)); // 37
`endif

    repeat (3) tick();
    RESET = 1'b0;
    #1;
    chk("rst.req", mem_req, 0);
    chk("rst.we", mem_we, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.wdata", mem_wdata, 0);
    chk("rst.data", cpu_data, 8'h00);
    chk("rst.wait_n", cpu_wait_n, 1);
    chk("rst.busy", dl_busy, 0);
    chk("rst.ovf", dl_ovf, 0);
    chk("rst.tmo", tmo_err, 0);
    tick();

    foreach (vecs[i]) begin
      cpu_oe = vecs[i].oe; cpu_addr = vecs[i].ca; dl_we = vecs[i].dw;
      dl_addr = vecs[i].da; dl_data = vecs[i].dd; mem_ack = vecs[i].ack;
      mem_rdata = vecs[i].rd;
      #1;
      chk($sformatf("r%0d.req", i), mem_req, vecs[i].req);
      chk($sformatf("r%0d.we", i), mem_we, vecs[i].we);
      if (vecs[i].req) chk($sformatf("r%0d.addr", i), mem_addr, vecs[i].addr);
      if (vecs[i].req && vecs[i].we) chk($sformatf("r%0d.wdata", i), mem_wdata, vecs[i].wd);
      chk($sformatf("r%0d.wait_n", i), cpu_wait_n, vecs[i].wn);
      chk($sformatf("r%0d.data", i), cpu_data, vecs[i].data);
      chk($sformatf("r%0d.busy", i), dl_busy, vecs[i].busy);
      chk($sformatf("r%0d.ovf", i), dl_ovf, vecs[i].ovf);
      chk($sformatf("r%0d.tmo", i), tmo_err, 0);
      tick();
    end
    dl_we = 1'b0; mem_ack = 1'b0;

    // Timeout: no ack ever arrives, ACK_TMO = 8
    tick();
    cpu_oe = 1'b1; cpu_addr = 15'h0100;
    #1;
    chk("tmo.miss_wait_n", cpu_wait_n, 0);
    n_hi = 0; ended = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mem_req) n_hi++;
      else if (n_hi != 0) begin
        ended = 1'b1;
        break;
      end
    end
    chk("tmo.req_dropped", ended, 1);
    chk("tmo.req_cycles", n_hi, 8);
    chk("tmo.err", tmo_err, 1);
    chk("tmo.wait_n", cpu_wait_n, 1);
    chk("tmo.data", cpu_data, 8'hFF);

    // Reset during a read, with an ack in the same cycle: no tag update
    cpu_addr = 15'h0200;
    ended = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_req) begin
        ended = 1'b1;
        break;
      end
    end
    chk("rstmid.req_seen", ended, 1);
    RESET = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h99;
    tick();
    chk("rstmid.req", mem_req, 0);
    chk("rstmid.tmo", tmo_err, 0);
    chk("rstmid.data", cpu_data, 8'h00);
    chk("rstmid.wait_n", cpu_wait_n, 0);
    // Stray ack while idle is ignored
    RESET = 1'b0; cpu_oe = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h55;
    tick();
    mem_ack = 1'b0; cpu_oe = 1'b1; cpu_addr = 15'h0200;
    #1;
    chk("stray.wait_n", cpu_wait_n, 0);
    chk("stray.data", cpu_data, 8'h00);
    chk("stray.req", mem_req, 0);
    tick();
    mem_ack = 1'b1; mem_rdata = 8'h12;
    #1;
    chk("post.req", mem_req, 1);
    chk("post.addr", mem_addr, 16'h0200);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("post.req_low", mem_req, 0);
    chk("post.wait_n", cpu_wait_n, 1);
    chk("post.data", cpu_data, 8'h12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
